// File: rtl/idli_pgrf_m.sv
// ---------------------------------------------------------------------------
// idli_pgrf_m -- bit-serial general purpose register file with program counter
//
// Every architectural register (1..NUM_REGS-1) rotates right by SLICE_W bits
// each cycle. The slice that sits in the bottom SLICE_W bits is the slice
// presented on the read ports this cycle, and the slice that enters at the top
// is either the old bottom slice (hold) or freshly written data. A word
// therefore takes NSLICE cycles to stream past, LSB slice first, and a slice
// written in cycle t reappears at the bottom in cycle t+NSLICE.
// Register 0 reads as constant zero and is never written.
//
// The program counter lives at index PC_IDX and additionally supports a
// serial +1 increment that ripples a carry between slices through a flop.
//
// Ports
//   i_pgrf_gck       clock (rising edge)
//   i_pgrf_rst       asynchronous active-high reset
//   i_pgrf_b/_c      read-port register selects
//   o_pgrf_b/c_data  current slice of the selected registers
//   i_pgrf_a         write-port register select
//   i_pgrf_a_vld     write current slice of register a
//   i_pgrf_a_data    write slice data
//   i_pgrf_pc_vld    explicit PC slice write
//   i_pgrf_pc_data   explicit PC slice data
//   i_pgrf_pc_inc    serially increment the PC this cycle
//   o_pgrf_pc_data   current PC slice (value before this cycle's update)
//   o_pgrf_slice     index of the slice presented this cycle
//   o_pgrf_pc_carry  carry out of this cycle's PC increment slice
// ---------------------------------------------------------------------------
module idli_pgrf_m #(
  parameter int               REG_W    = 16,
  parameter int               SLICE_W  = 4,
  parameter int               NUM_REGS = 8,
  parameter int               PC_IDX   = NUM_REGS - 1,
  parameter logic [REG_W-1:0] RESET_PC = '0,
  localparam int              NSLICE   = REG_W / SLICE_W,
  localparam int              IDX_W    = $clog2(NUM_REGS),
  localparam int              SL_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               i_pgrf_gck,
  input  logic               i_pgrf_rst,
  input  logic [IDX_W-1:0]   i_pgrf_b,
  input  logic [IDX_W-1:0]   i_pgrf_c,
  output logic [SLICE_W-1:0] o_pgrf_b_data,
  output logic [SLICE_W-1:0] o_pgrf_c_data,
  input  logic [IDX_W-1:0]   i_pgrf_a,
  input  logic               i_pgrf_a_vld,
  input  logic [SLICE_W-1:0] i_pgrf_a_data,
  input  logic               i_pgrf_pc_vld,
  input  logic [SLICE_W-1:0] i_pgrf_pc_data,
  input  logic               i_pgrf_pc_inc,
  output logic [SLICE_W-1:0] o_pgrf_pc_data,
  output logic [SL_W-1:0]    o_pgrf_slice,
  output logic               o_pgrf_pc_carry
);

  logic [REG_W-1:0]   regs_q [NUM_REGS];
  logic [REG_W-1:0]   regs_d [NUM_REGS];
  logic [SL_W-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;

  logic               cin;
  logic [SLICE_W:0]   pc_sum;
  logic               pc_wr_a;
  logic               pc_hi_wr;
  logic [SLICE_W-1:0] new_slice;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a value before any conditional
    // override, so no path leaves one unassigned and no latch is inferred.
    new_slice = '0;
    regs_d[0] = '0;

    // The increment always injects +1 at slice 0; later slices take the
    // carry left behind by the previous slice.
    cin      = (cnt_q == '0) ? 1'b1 : carry_q;
    pc_sum   = {1'b0, regs_q[PC_IDX][SLICE_W-1:0]} + {{SLICE_W{1'b0}}, cin};
    pc_wr_a  = i_pgrf_a_vld && (i_pgrf_a == IDX_W'(PC_IDX));
    pc_hi_wr = pc_wr_a || i_pgrf_pc_vld;

    o_pgrf_pc_carry = i_pgrf_pc_inc & pc_sum[SLICE_W];

    for (int i = 1; i < NUM_REGS; i++) begin
      new_slice = regs_q[i][SLICE_W-1:0];
      if (i == PC_IDX) begin
        if (pc_wr_a)            new_slice = i_pgrf_a_data;
        else if (i_pgrf_pc_vld) new_slice = i_pgrf_pc_data;
        else if (i_pgrf_pc_inc) new_slice = pc_sum[SLICE_W-1:0];
      end else if (i_pgrf_a_vld && (i_pgrf_a == IDX_W'(i))) begin
        new_slice = i_pgrf_a_data;
      end
      // Rotate right: the chosen slice enters at the top.
      regs_d[i] = REG_W'({new_slice, regs_q[i]} >> SLICE_W);
    end

    // An explicit PC write breaks the carry chain; the carry out of the top
    // slice is dropped so the PC wraps modulo 2^REG_W.
    if (pc_hi_wr || (cnt_q == SL_W'(NSLICE - 1))) carry_d = 1'b0;
    else                                         carry_d = o_pgrf_pc_carry;

    cnt_d = (cnt_q == SL_W'(NSLICE - 1)) ? '0 : cnt_q + 1'b1;
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge i_pgrf_gck or posedge i_pgrf_rst) begin
    if (i_pgrf_rst) begin
      // NOTE: the register array is small and its reset contents are
      // architecturally visible (zeros and the boot PC), so it is reset like
      // any other flop rather than treated as an uninitialised RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
      end
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values that
      // existed before this edge, independent of statement order.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    o_pgrf_b_data = '0;
    o_pgrf_c_data = '0;
    if ((i_pgrf_b != '0) && (32'(i_pgrf_b) < NUM_REGS))
      o_pgrf_b_data = regs_q[i_pgrf_b][SLICE_W-1:0];
    if ((i_pgrf_c != '0) && (32'(i_pgrf_c) < NUM_REGS))
      o_pgrf_c_data = regs_q[i_pgrf_c][SLICE_W-1:0];
  end

  assign o_pgrf_pc_data = regs_q[PC_IDX][SLICE_W-1:0];
  assign o_pgrf_slice   = cnt_q;

endmodule

// File: tb/tb_idli_pgrf_m.sv
// ---------------------------------------------------------------------------
// tb_idli_pgrf_m -- self-checking bench for idli_pgrf_m
//
// Two instances: u0 uses the default geometry (16-bit words, 4-bit slices,
// 8 registers) with a boot PC of 16'h1234; u1 uses 8-bit slices and 16
// registers. Only one instance runs at a time; the other is held in reset.
// The reference model keeps whole architectural words and derives each
// cycle's expected slice by shifting, so it never mirrors the rotation.
// ---------------------------------------------------------------------------
module tb_idli_pgrf_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0 signals
  logic       rst0;
  logic [2:0] b0, c0, a0;
  logic       avld0, pcv0, inc0;
  logic [3:0] ad0, pcd0;
  logic [3:0] ob0, oc0, opc0;
  logic [1:0] osl0;
  logic       ocy0;

  // u1 signals
  logic       rst1;
  logic [3:0] b1, c1, a1;
  logic       avld1, pcv1, inc1;
  logic [7:0] ad1, pcd1;
  logic [7:0] ob1, oc1, opc1;
  logic [0:0] osl1;
  logic       ocy1;

  idli_pgrf_m #(.RESET_PC(16'h1234)) u0 (
    .i_pgrf_gck(clk), .i_pgrf_rst(rst0),
    .i_pgrf_b(b0), .i_pgrf_c(c0),
    .o_pgrf_b_data(ob0), .o_pgrf_c_data(oc0),
    .i_pgrf_a(a0), .i_pgrf_a_vld(avld0), .i_pgrf_a_data(ad0),
    .i_pgrf_pc_vld(pcv0), .i_pgrf_pc_data(pcd0), .i_pgrf_pc_inc(inc0),
    .o_pgrf_pc_data(opc0), .o_pgrf_slice(osl0), .o_pgrf_pc_carry(ocy0)
  );

  idli_pgrf_m #(.SLICE_W(8), .NUM_REGS(16)) u1 (
    .i_pgrf_gck(clk), .i_pgrf_rst(rst1),
    .i_pgrf_b(b1), .i_pgrf_c(c1),
    .o_pgrf_b_data(ob1), .o_pgrf_c_data(oc1),
    .i_pgrf_a(a1), .i_pgrf_a_vld(avld1), .i_pgrf_a_data(ad1),
    .i_pgrf_pc_vld(pcv1), .i_pgrf_pc_data(pcd1), .i_pgrf_pc_inc(inc1),
    .o_pgrf_pc_data(opc1), .o_pgrf_slice(osl1), .o_pgrf_pc_carry(ocy1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  // ---------------- reference model ----------------
  int m_reg   [2][16];
  int m_slice [2];
  int m_carry [2];

  function automatic int sw(input int d);    return (d == 0) ? 4 : 8;     endfunction
  function automatic int ns(input int d);    return 16 / sw(d);           endfunction
  function automatic int pci(input int d);   return (d == 0) ? 7 : 15;    endfunction
  function automatic int nregs(input int d); return (d == 0) ? 8 : 16;    endfunction
  function automatic int mask(input int d);  return (1 << sw(d)) - 1;     endfunction

  function automatic int field(input int d, input int w, input int s);
    return (w >> (sw(d) * s)) & mask(d);
  endfunction

  task automatic set_field(input int d, input int r, input int s, input int v);
    int sh;
    sh = sw(d) * s;
    m_reg[d][r] = (m_reg[d][r] & ~(mask(d) << sh)) | ((v & mask(d)) << sh);
  endtask

  task automatic model_reset(input int d);
    for (int i = 0; i < 16; i++) m_reg[d][i] = 0;
    m_reg[d][pci(d)] = (d == 0) ? 'h1234 : 0;
    m_slice[d] = 0;
    m_carry[d] = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on instance d: drive, compare against the model, advance.
  task automatic cyc(input int d, input int b, input int c, input int a,
                     input int avld, input int adata, input int pcvld,
                     input int pcdata, input int pcinc);
    int    eb, ec, epc, cin, sum, ecy, s;
    string t;
    if (d == 0) begin
      b0 = 3'(b); c0 = 3'(c); a0 = 3'(a); avld0 = avld[0]; ad0 = 4'(adata);
      pcv0 = pcvld[0]; pcd0 = 4'(pcdata); inc0 = pcinc[0];
    end else begin
      b1 = 4'(b); c1 = 4'(c); a1 = 4'(a); avld1 = avld[0]; ad1 = 8'(adata);
      pcv1 = pcvld[0]; pcd1 = 8'(pcdata); inc1 = pcinc[0];
    end
    #1;
    s   = m_slice[d];
    eb  = (b == 0 || b >= nregs(d)) ? 0 : field(d, m_reg[d][b], s);
    ec  = (c == 0 || c >= nregs(d)) ? 0 : field(d, m_reg[d][c], s);
    epc = field(d, m_reg[d][pci(d)], s);
    cin = (s == 0) ? 1 : m_carry[d];
    sum = epc + cin;
    ecy = pcinc[0] ? ((sum >> sw(d)) & 1) : 0;
    t   = $sformatf("u%0d cyc%0d slice%0d", d, n_cyc, s);
    if (d == 0) begin
      chk({t, " b_data"},   32'(ob0),  eb);
      chk({t, " c_data"},   32'(oc0),  ec);
      chk({t, " pc_data"},  32'(opc0), epc);
      chk({t, " slice"},    32'(osl0), s);
      chk({t, " pc_carry"}, 32'(ocy0), ecy);
    end else begin
      chk({t, " b_data"},   32'(ob1),  eb);
      chk({t, " c_data"},   32'(oc1),  ec);
      chk({t, " pc_data"},  32'(opc1), epc);
      chk({t, " slice"},    32'(osl1), s);
      chk({t, " pc_carry"}, 32'(ocy1), ecy);
    end
    // architectural update
    if (avld != 0 && a != 0 && a < nregs(d) && a != pci(d)) set_field(d, a, s, adata);
    if (avld != 0 && a == pci(d)) set_field(d, pci(d), s, adata);
    else if (pcvld != 0)          set_field(d, pci(d), s, pcdata);
    else if (pcinc != 0)          set_field(d, pci(d), s, sum);
    m_carry[d] = ((avld != 0 && a == pci(d)) || pcvld != 0 || s == ns(d) - 1) ? 0 : ecy;
    m_slice[d] = (s + 1) % ns(d);
    n_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int b, input int c);
    cyc(d, b, c, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pc_load(input int d, input int word);
    for (int s = 0; s < ns(d); s++)
      cyc(d, pci(d), 0, 0, 0, 0, 1, field(d, word, s), 0);
  endtask

  task automatic pc_incr_word(input int d);
    for (int s = 0; s < ns(d); s++)
      cyc(d, pci(d), 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rand_cycle(input int d);
    int b, c, a, avld, pcv, inc;
    b    = $urandom_range(0, nregs(d) - 1);
    c    = $urandom_range(0, nregs(d) - 1);
    a    = $urandom_range(0, nregs(d) - 1);
    avld = $urandom_range(0, 1);
    pcv  = ($urandom_range(0, 3) == 0) ? 1 : 0;
    inc  = $urandom_range(0, 1);
    if ((avld != 0 && a == pci(d)) || pcv != 0) inc = 0;
    cyc(d, b, c, a, avld, $urandom & mask(d), pcv, $urandom & mask(d), inc);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0 = 3'd3; c0 = 3'd7; a0 = '0; avld0 = 0; ad0 = '0; pcv0 = 0; pcd0 = '0; inc0 = 0;
    b1 = '0; c1 = '0; a1 = '0; avld1 = 0; ad1 = '0; pcv1 = 0; pcd1 = '0; inc1 = 0;

    // ---- reset state of u0 ----
    @(posedge clk); #1;
    chk("reset b_data r3",   32'(ob0),  0);
    chk("reset c_data pc",   32'(oc0),  4);
    chk("reset pc_data",     32'(opc0), 4);
    chk("reset slice",       32'(osl0), 0);
    chk("reset pc_carry",    32'(ocy0), 0);

    // ---- boot PC streams 4,3,2,1 repeatedly ----
    model_reset(0);
    rst0 = 1'b0;
    for (int i = 0; i < 8; i++) idle(0, 7, 0);

    // ---- write r3 = BEEF, no bypass while writing, then read back ----
    for (int s = 0; s < 4; s++) cyc(0, 3, 0, 3, 1, ('hBEEF >> (4 * s)) & 'hF, 0, 0, 0);
    for (int i = 0; i < 8; i++) idle(0, 3, 0);

    // ---- 00FF + 1 = 0100 with carries 1,1,0,0 ----
    pc_load(0, 'h00FF);
    pc_incr_word(0);
    for (int i = 0; i < 4; i++) idle(0, 7, 3);

    // ---- FFFF + 1 wraps to 0000 ----
    pc_load(0, 'hFFFF);
    pc_incr_word(0);
    for (int i = 0; i < 4; i++) idle(0, 7, 0);

    // ---- priority at slice 1: a-write beats pc_vld beats inc; carry cleared ----
    pc_load(0, 'hFF0F);
    cyc(0, 7, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 7, 0, 7, 1, 5, 1, 9, 1);
    cyc(0, 7, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 7, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(0, 7, 0);

    // ---- randomized traffic ----
    for (int i = 0; i < 200; i++) rand_cycle(0);

    // ---- reset asserted at slice 2 in the middle of a write to r2 ----
    for (int i = 0; i < 4 && m_slice[0] != 0; i++) idle(0, 2, 0);
    cyc(0, 2, 0, 2, 1, 'hA, 0, 0, 0);
    cyc(0, 2, 0, 2, 1, 'h5, 0, 0, 0);
    b0 = 3'd2; c0 = 3'd0; a0 = 3'd2; avld0 = 1'b1; ad0 = 4'h3;
    #2;
    rst0 = 1'b1;
    #1;
    chk("midreset b_data r2", 32'(ob0),  0);
    chk("midreset slice",     32'(osl0), 0);
    chk("midreset pc_data",   32'(opc0), 4);
    @(posedge clk); #1;
    chk("midreset held slice", 32'(osl0), 0);
    model_reset(0);
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) idle(0, 2, 7);

    // ---- second geometry: 8-bit slices, 16 registers ----
    rst0 = 1'b1;
    model_reset(1);
    rst1 = 1'b0;
    for (int s = 0; s < 2; s++) cyc(1, 3, 0, 3, 1, ('hBEEF >> (8 * s)) & 'hFF, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(1, 3, 0);
    pc_load(1, 'h00FF);
    pc_incr_word(1);
    for (int i = 0; i < 2; i++) idle(1, 15, 3);
    for (int i = 0; i < 100; i++) rand_cycle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
